// File: rtl/permutation_controller_pkg.sv
// Shared definitions for the permutation control FSM.
//   - 3-bit state encoding constants (IDLE, LOAD, RINIT, SLICE, RNEXT, UNLOAD, DONE)
//   - SLICES : slice steps per round (the external slice counter's terminal count)
//   - WORDS_DEF / ROUNDS_DEF : default lane words per load/unload and rounds per start
package permutation_controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_RINIT  = 3'd2;
  localparam state_t ST_SLICE  = 3'd3;
  localparam state_t ST_RNEXT  = 3'd4;
  localparam state_t ST_UNLOAD = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  localparam int SLICES     = 64;
  localparam int WORDS_DEF  = 25;
  localparam int ROUNDS_DEF = 24;

endpackage

// File: rtl/permutation_controller.sv
// Control FSM for the permutation function.
// Loads WORDS lane words over a valid/ready port, runs ROUNDS rounds of SLICES
// slice steps (paced by an external slice counter), then unloads WORDS words.
// Ports:
//   clk, rst (async, active-low)
//   start                : begin an operation (sampled only in IDLE)
//   in_valid / in_ready  : input word handshake; mem_wr writes the accepted word
//   out_valid / out_ready: output word handshake; word_idx is the read address
//   cnt_co / cnt_inc / cnt_init : external slice counter interface
//   slice_en             : datapath processes the current slice
//   word_idx, round_idx  : lane index and current round
//   busy, done           : activity flag and one-cycle completion pulse
module permutation_controller
  import permutation_controller_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int IW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  input  logic          cnt_co,
  output logic          cnt_inc,
  output logic          cnt_init,
  output logic          slice_en,
  output logic          mem_wr,
  output logic [IW-1:0] word_idx,
  output logic [IW-1:0] round_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [IW-1:0] WORD_LAST  = IW'(WORDS - 1);
  localparam logic [IW-1:0] ROUND_LAST = IW'(ROUNDS - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [IW-1:0] round_idx_q, round_idx_d;

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    round_idx_d = round_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          word_idx_d = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (word_idx_q == WORD_LAST) begin
            word_idx_d = '0;
            state_d    = ST_RINIT;
          end else begin
            word_idx_d = word_idx_q + IW'(1);
          end
        end
      end
      ST_RINIT: state_d = ST_SLICE;
      // The counter reports co one cycle after its last increment; that
      // cycle does no slice work and just hands over to RNEXT.
      ST_SLICE: begin
        if (cnt_co) state_d = ST_RNEXT;
      end
      ST_RNEXT: begin
        if (round_idx_q == ROUND_LAST) begin
          round_idx_d = '0;
          state_d     = ST_UNLOAD;
        end else begin
          round_idx_d = round_idx_q + IW'(1);
          state_d     = ST_RINIT;
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          if (word_idx_q == WORD_LAST) begin
            word_idx_d = '0;
            state_d    = ST_DONE;
          end else begin
            word_idx_d = word_idx_q + IW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Moore decode, except the handshake/counter strobes which are qualified
  // by in_valid and cnt_co so no spurious write or increment is issued.
  assign in_ready  = (state_q == ST_LOAD);
  assign mem_wr    = (state_q == ST_LOAD) && in_valid;
  assign cnt_init  = (state_q == ST_RINIT);
  assign slice_en  = (state_q == ST_SLICE) && !cnt_co;
  assign cnt_inc   = (state_q == ST_SLICE) && !cnt_co;
  assign out_valid = (state_q == ST_UNLOAD);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign word_idx  = word_idx_q;
  assign round_idx = round_idx_q;

endmodule
